// File: rtl/pacman_pkg.sv
// Shared encodings for the Pac-Man motion controller and renderer.
// Exports direction, keypad-code and controller-state encodings.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  localparam logic [1:0] KEY_NONE  = 2'b00;
  localparam logic [1:0] VIR_UP    = 2'b01;
  localparam logic [1:0] VIR_DOWN  = 2'b10;
  localparam logic [1:0] HOR_LEFT  = 2'b01;
  localparam logic [1:0] HOR_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    IDLE     = 2'd1,
    MOVE     = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

endpackage

// File: rtl/pacman_motion_ctrl_if.sv
// Position-update bundle from the motion controller to the renderer.
// master drives pos_x/pos_y/frame/dir/upd_req; slave returns upd_ack.
interface pacman_motion_ctrl_if;

  logic [6:0] pos_x;
  logic [5:0] pos_y;
  logic       frame;
  logic [1:0] dir;
  logic       upd_req;
  logic       upd_ack;

  modport master (
    output pos_x, pos_y, frame, dir, upd_req,
    input  upd_ack
  );

  modport slave (
    input  pos_x, pos_y, frame, dir, upd_req,
    output upd_ack
  );

endinterface

// File: rtl/pacman_motion_ctrl_step_prescaler.sv
// Step prescaler: counts 0..DIV-1 while en, tc pulses on the last count.
// Ports: clk, rst (sync, high), clr (force 0), en, tc.
module step_prescaler #(
  parameter int DIV = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Keypad direction to sprite position, one pixel per STEP_DIV clocks.
// Ports: clk, rst (sync, high), vir/hor keys, upd (position + req/ack).
module pacman_motion_ctrl
  import pacman_pkg::*;
#(
  parameter int STEP_DIV = 10000,
  parameter int X_MAX    = 120,
  parameter int Y_MAX    = 56,
  parameter int X_INIT   = 60,
  parameter int Y_INIT   = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  vir,
  input  logic [1:0]                  hor,
  pacman_motion_ctrl_if.master        upd
);

  localparam logic [6:0] XM = 7'(X_MAX);
  localparam logic [5:0] YM = 6'(Y_MAX);

  state_t     state, state_n;
  dir_t       dir, dir_n;
  logic [6:0] x, x_n, x_step;
  logic [5:0] y, y_n, y_step;
  logic       frame, frame_n;
  logic       req, req_n;
  logic       moving, moving_n;

  logic       v_ok, h_ok, key_valid;
  dir_t       key_dir, dir_eff;
  logic       pre_clr, pre_en, pre_tc;

  step_prescaler #(.DIV(STEP_DIV)) u_pre (
    .clk (clk),
    .rst (rst),
    .clr (pre_clr),
    .en  (pre_en),
    .tc  (pre_tc)
  );

  // Vertical keys win over horizontal; code 11 counts as no key.
  assign v_ok = (vir == VIR_UP) || (vir == VIR_DOWN);
  assign h_ok = (hor == HOR_LEFT) || (hor == HOR_RIGHT);
  assign key_valid = v_ok || h_ok;

  always_comb begin
    key_dir = DIR_RIGHT;
    unique case (1'b1)
      v_ok:
        key_dir = (vir == VIR_UP) ? DIR_UP : DIR_DOWN;
      !v_ok && h_ok:
        key_dir = (hor == HOR_LEFT) ? DIR_LEFT : DIR_RIGHT;
      default:
        key_dir = DIR_RIGHT;
    endcase
  end

  assign dir_eff = key_valid ? key_dir : dir;

  // Wrap by compare-and-select so odd ranges work too.
  always_comb begin
    x_step = x;
    y_step = y;
    unique case (dir_eff)
      DIR_RIGHT: x_step = (x == XM) ? 7'd0 : x + 7'd1;
      DIR_LEFT:  x_step = (x == 7'd0) ? XM : x - 7'd1;
      DIR_UP:    y_step = (y == 6'd0) ? YM : y - 6'd1;
      DIR_DOWN:  y_step = (y == YM) ? 6'd0 : y + 6'd1;
      default:   x_step = x;
    endcase
  end

  always_comb begin
    state_n  = state;
    dir_n    = dir;
    x_n      = x;
    y_n      = y;
    frame_n  = frame;
    req_n    = req;
    moving_n = moving;
    pre_clr  = 1'b1;
    pre_en   = 1'b0;
    unique case (state)
      INIT: begin
        state_n = WAIT_ACK;
        req_n   = 1'b1;
      end
      IDLE: begin
        dir_n    = dir_eff;
        moving_n = moving | key_valid;
        if (key_valid) state_n = MOVE;
      end
      MOVE: begin
        dir_n    = dir_eff;
        moving_n = moving | key_valid;
        pre_clr  = 1'b0;
        pre_en   = 1'b1;
        if (pre_tc) begin
          x_n     = x_step;
          y_n     = y_step;
          frame_n = ~frame;
          req_n   = 1'b1;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        dir_n    = dir_eff;
        moving_n = moving | key_valid;
        if (req && upd.upd_ack) begin
          req_n   = 1'b0;
          state_n = (moving | key_valid) ? MOVE : IDLE;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      dir    <= DIR_RIGHT;
      x      <= 7'(X_INIT);
      y      <= 6'(Y_INIT);
      frame  <= 1'b0;
      req    <= 1'b0;
      moving <= 1'b0;
    end else begin
      state  <= state_n;
      dir    <= dir_n;
      x      <= x_n;
      y      <= y_n;
      frame  <= frame_n;
      req    <= req_n;
      moving <= moving_n;
    end
  end

  assign upd.pos_x   = x;
  assign upd.pos_y   = y;
  assign upd.frame   = frame;
  assign upd.dir     = dir;
  assign upd.upd_req = req;

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Randomised self-checking bench for pacman_motion_ctrl.
// Compares every cycle against a behavioural sprite model.
module tb_pacman_motion_ctrl;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic [1:0] vir;
  logic [1:0] hor;

  int checks;
  int errors;

  pacman_motion_ctrl_if u_if ();

  pacman_motion_ctrl #(
    .STEP_DIV (DIV),
    .X_MAX    (120),
    .Y_MAX    (56),
    .X_INIT   (60),
    .Y_INIT   (28)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vir (vir),
    .hor (hor),
    .upd (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: sprite at (mx,my), heading mdir, a pending post mreq,
  // mtick clocks spent walking toward the next step.
  int mx, my, mdir, mtick;
  bit mframe, mreq, mmoving, minit;

  task automatic model_clock(input bit r, input bit [1:0] v,
                             input bit [1:0] h, input bit a);
    bit kv;
    int d;
    if (r) begin
      mx = 60; my = 28; mdir = 0; mtick = 0;
      mframe = 0; mreq = 0; mmoving = 0; minit = 1;
      return;
    end
    if (minit) begin
      minit = 0;
      mreq = 1;
      return;
    end
    kv = 1;
    if (v == 1) d = 2;
    else if (v == 2) d = 3;
    else if (h == 1) d = 1;
    else if (h == 2) d = 0;
    else begin kv = 0; d = mdir; end
    if (mreq) begin
      if (a) mreq = 0;
    end else if (mmoving) begin
      if (mtick == DIV - 1) begin
        mtick = 0;
        case (d)
          0: mx = (mx == 120) ? 0 : mx + 1;
          1: mx = (mx == 0) ? 120 : mx - 1;
          2: my = (my == 0) ? 56 : my - 1;
          default: my = (my == 56) ? 0 : my + 1;
        endcase
        mframe = !mframe;
        mreq = 1;
      end else begin
        mtick++;
      end
    end
    if (kv) mmoving = 1;
    mdir = d;
  endtask

  function automatic logic [16:0] expv();
    return {7'(mx), 6'(my), mframe, 2'(mdir), mreq};
  endfunction

  function automatic logic [16:0] gotv();
    return {u_if.pos_x, u_if.pos_y, u_if.frame,
            u_if.dir, u_if.upd_req};
  endfunction

  task automatic tick(input bit r, input bit [1:0] v,
                      input bit [1:0] h, input bit a);
    rst = r;
    vir = v;
    hor = h;
    u_if.upd_ack = a;
    @(posedge clk);
    model_clock(r, v, h, a);
    #1;
  endtask

  task automatic test_reset();
    int nreq;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 1);
      checks++;
      if (gotv() !== expv()) begin
        errors++;
        $display("FAIL reset got %h exp %h", gotv(), expv());
      end
    end
    nreq = 0;
    for (int i = 0; i < 105; i++) begin
      tick(0, 0, 0, 1);
      if (u_if.upd_req === 1'b1) nreq++;
      checks++;
      if (gotv() !== expv()) begin
        errors++;
        $display("FAIL reset_post cyc %0d got %h exp %h",
                 i, gotv(), expv());
      end
    end
    checks++;
    if (nreq !== 1) begin
      errors++;
      $display("FAIL reset_req_count got %0d exp 1", nreq);
    end
  endtask

  task automatic test_move_right();
    for (int i = 0; i < 60; i++) begin
      tick(0, 0, 2, mreq);
      checks++;
      if (gotv() !== expv()) begin
        errors++;
        $display("FAIL move_right cyc %0d got %h exp %h",
                 i, gotv(), expv());
      end
    end
    checks++;
    if (u_if.pos_y !== 6'd28) begin
      errors++;
      $display("FAIL move_right_y got %0d exp 28", u_if.pos_y);
    end
  endtask

  task automatic test_wrap();
    int pv[4] = '{0, 0, 2, 1};
    int ph[4] = '{2, 1, 0, 0};
    int px, py, want, got;
    bit pr, done;
    for (int p = 0; p < 4; p++) begin
      done = 0;
      for (int n = 0; n < 2000 && !done; n++) begin
        px = mx;
        py = my;
        pr = mreq;
        tick(0, 2'(pv[p]), 2'(ph[p]), mreq);
        checks++;
        if (gotv() !== expv()) begin
          errors++;
          $display("FAIL wrap_trace p%0d got %h exp %h",
                   p, gotv(), expv());
        end
        if (!pr && mreq) begin
          case (p)
            0: begin done = (px == 120); want = 0;
                     got = int'(u_if.pos_x); end
            1: begin done = (px == 0); want = 120;
                     got = int'(u_if.pos_x); end
            2: begin done = (py == 56); want = 0;
                     got = int'(u_if.pos_y); end
            default: begin done = (py == 0); want = 56;
                     got = int'(u_if.pos_y); end
          endcase
          if (done) begin
            checks++;
            if (got !== want) begin
              errors++;
              $display("FAIL wrap p%0d got %0d exp %0d",
                       p, got, want);
            end
          end
        end
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL wrap_timeout p%0d", p);
      end
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 30; i++) begin
      tick(0, 1, 2, mreq);
      checks++;
      if (gotv() !== expv()) begin
        errors++;
        $display("FAIL prio_up cyc %0d got %h exp %h",
                 i, gotv(), expv());
      end
    end
    checks++;
    if (u_if.dir !== 2'd2) begin
      errors++;
      $display("FAIL prio_up_dir got %0d exp 2", u_if.dir);
    end
    for (int i = 0; i < 30; i++) begin
      tick(0, 3, 1, mreq);
      checks++;
      if (gotv() !== expv()) begin
        errors++;
        $display("FAIL prio_inv cyc %0d got %h exp %h",
                 i, gotv(), expv());
      end
    end
    checks++;
    if (u_if.dir !== 2'd1) begin
      errors++;
      $display("FAIL prio_inv_dir got %0d exp 1", u_if.dir);
    end
  endtask

  task automatic test_stall();
    int k;
    for (int n = 0; n < 20 && !mreq; n++) tick(0, 0, 2, 0);
    for (int i = 0; i < 50; i++) begin
      tick(0, 0, 2, 0);
      checks++;
      if (gotv() !== expv() || u_if.upd_req !== 1'b1) begin
        errors++;
        $display("FAIL stall cyc %0d got %h exp %h",
                 i, gotv(), expv());
      end
    end
    tick(0, 0, 2, 1);
    checks++;
    if (u_if.upd_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_drop got %b exp 0", u_if.upd_req);
    end
    k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      tick(0, 0, 2, 0);
      if (u_if.upd_req === 1'b1) k = i;
      checks++;
      if (gotv() !== expv()) begin
        errors++;
        $display("FAIL stall_resume cyc %0d got %h exp %h",
                 i, gotv(), expv());
      end
    end
    checks++;
    if (k !== DIV) begin
      errors++;
      $display("FAIL stall_gap got %0d exp %0d", k, DIV);
    end
    tick(0, 0, 2, 1);
  endtask

  task automatic test_reset_in_wait();
    for (int n = 0; n < 20 && !mreq; n++) tick(0, 1, 1, 0);
    tick(0, 1, 1, 0);
    tick(1, 1, 1, 0);
    checks++;
    if (u_if.upd_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_req got %b exp 0", u_if.upd_req);
    end
    tick(0, 0, 0, 1);
    checks++;
    if (u_if.upd_req !== 1'b1 || u_if.pos_x !== 7'd60 ||
        u_if.pos_y !== 6'd28) begin
      errors++;
      $display("FAIL rst_wait_post got %b %0d %0d exp 1 60 28",
               u_if.upd_req, u_if.pos_x, u_if.pos_y);
    end
    tick(0, 0, 0, 1);
    checks++;
    if (gotv() !== expv()) begin
      errors++;
      $display("FAIL rst_wait_after got %h exp %h",
               gotv(), expv());
    end
  endtask

  task automatic test_random();
    bit [1:0] v, h;
    bit a, r;
    v = 0;
    h = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        v = 2'($urandom_range(0, 3));
        h = 2'($urandom_range(0, 3));
      end
      a = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 499) == 0);
      tick(r, v, h, a);
      checks++;
      if (gotv() !== expv()) begin
        errors++;
        $display("FAIL random cyc %0d got %h exp %h",
                 i, gotv(), expv());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    vir = 2'b00;
    hor = 2'b00;
    u_if.upd_ack = 1'b0;
    test_reset();
    test_move_right();
    test_wrap();
    test_priority();
    test_stall();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
